ingress_framer: RTL and testbench
=================================

Name: ingress_framer

Overview:
- Sits at the ingress of the inspection path and drives the shared frame stream that feeds both the delay FIFO and the detection engine.
- Accepts a non-backpressured Avalon-ST stream of type avln_st and emits a well-formed frame stream: every sop matched by an eop, length bounded.
- Emits per-frame start and valid strobes, plus the running frame index consumed by the downstream drop/decision stage.
- Discards whole frames at sop when the delay FIFO is almost full, so sop counts stay identical on both sides of the FIFO.

Parameters:
CTR_SIZE, 24, width of the frame index counter; must match the decision stage.
MIN_BEATS, 4, minimum frame length in beats for a valid strobe.
MAX_BEATS, 256, maximum frame length in beats before forced truncation.
STAT_W, 16, width of the saturating statistics counters.

Ports:
sys_clk  in  1  system clock.
reset  in  1  asynchronous reset, active-high.
in  in  avln_st  raw ingress stream; no ready signal, beat accepted when in.valid=1.
fifo_afull  in  1  delay FIFO almost-full; FIFO reserves at least MAX_BEATS+1 entries above this threshold.
out  out  avln_st  cleaned stream to the delay FIFO and the decision stage.
start  out  1  one-cycle pulse coincident with each forwarded out.sop.
valid  out  1  one-cycle pulse coincident with out.eop of a frame of length >= MIN_BEATS that was not truncated.
frame_index  out  CTR_SIZE  index of the frame currently or most recently forwarded.
discard_cnt  out  STAT_W  frames discarded because of fifo_afull.
runt_cnt  out  STAT_W  forwarded frames shorter than MIN_BEATS.
err_cnt  out  STAT_W  protocol errors: orphan beats, missing eop, oversize frames.

Behaviour:
- Reset: all outputs 0; state IDLE; frame_len 0. frame_index resets to 0.
- Latency: fixed 1 cycle from in beat to out beat. out is fully registered; out.valid=0 on any cycle with nothing to forward.
- frame_len has width $clog2(MAX_BEATS+1) and counts forwarded beats of the current frame.
- IDLE state:
  - in.valid & in.sop & fifo_afull: beat dropped; discard_cnt++; go to DISCARD (stay in IDLE if in.eop is set on the same beat).
  - in.valid & in.sop & ~fifo_afull: forward the beat; start=1; frame_len=1; go to PASS.
  - Single-beat frame (sop & eop): forward with eop; go straight back to IDLE; counts as a runt if MIN_BEATS>1.
  - in.valid & ~in.sop: orphan beat dropped; err_cnt++ per beat.
- PASS state, beat with in.valid & ~in.sop:
  - Forward the beat; frame_len++.
  - in.eop: valid=1 if frame_len+1 >= MIN_BEATS, else runt_cnt++; go to IDLE.
  - frame_len+1 == MAX_BEATS and ~in.eop: forward with out.eop forced to 1 and out.empty=0; no valid strobe; err_cnt++; go to DISCARD.
- PASS state, beat with in.valid & in.sop (missing eop on the previous frame):
  - The incoming beat is dropped.
  - Emit a synthetic beat: valid=1, eop=1, sop=0, data=0, empty=0. This closes the open frame with no valid strobe.
  - err_cnt++; go to DISCARD. The new frame is lost.
- fifo_afull is sampled only at sop; a frame already in PASS always completes.
- DISCARD state: drop all beats until in.valid & in.eop, then go to IDLE. A sop beat in DISCARD is treated exactly as in IDLE on that cycle.
- frame_index increments by 1 on every forwarded sop, registered together with out. It wraps modulo 2^CTR_SIZE with no flag.
- Statistics counters saturate at 2^STAT_W-1. When several events occur on one beat, each counter increments at most once per cycle.
- Reset asserted mid-frame: output stops immediately and state returns to IDLE. The downstream stage is also reset, so no closing eop is generated.

Decomposition:
- global_types: avln_st (already present). Add the state enum ingr_state_e {IDLE, PASS, DISCARD} and a sat_inc helper function.
- Sub-module sat_counter (parameter W; inputs inc and clear; output count) for the three statistics counters.

Test Plan:
- Three frames of 5, 8 and 5 beats back-to-back, fifo_afull=0 -> identical out one cycle later; 3 start and 3 valid pulses; frame_index steps 1,2,3; all statistics 0.
- fifo_afull=1 at sop of the 2nd of 3 frames, dropped to 0 mid-frame -> frame 2 is absent from out; discard_cnt=1; frame_index ends at 2.
- Frame of 300 beats with MAX_BEATS=256 -> 256 beats forwarded, the 256th with eop; no valid pulse; err_cnt=1; next frame forwarded normally.
- Frame A of 6 beats with no eop, then frame B sop, then B's eop -> A's 6 beats plus one synthetic eop beat; B dropped; err_cnt=1; only 1 start pulse.
- Two orphan beats, then a 2-beat frame with MIN_BEATS=4 -> err_cnt=2; frame forwarded; runt_cnt=1; no valid pulse.
- Reset pulsed at beat 3 of a 10-beat frame, then a clean 5-beat frame -> all outputs 0 during reset; remaining beats of the first frame dropped as orphans; clean frame forwarded with frame_index=1.

Source files
------------

// File: rtl/ingress_framer_pkg.sv
// Shared types for the ingress framer: the Avalon-ST beat, the framer state
// and a width-generic saturating increment.
package ingress_framer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned EMPTY_W = 2;

  typedef struct packed {
    logic               valid;
    logic               sop;
    logic               eop;
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
  } avln_st;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DISCARD
  } ingr_state_e;

  // Holds at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ingress_framer_sat_counter.sv
// Saturating event counter used for the framer statistics.
module sat_counter
  import ingress_framer_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= W'(sat_inc(32'(count), W));
    end
  end

endmodule

// File: rtl/ingress_framer.sv
// Ingress framer: cleans a non-backpressured Avalon-ST stream into well-formed,
// length-bounded frames, dropping whole frames at sop while the delay FIFO is almost full.
module ingress_framer
  import ingress_framer_pkg::*;
#(
  parameter int unsigned CTR_SIZE  = 24,
  parameter int unsigned MIN_BEATS = 4,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned STAT_W    = 16
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  avln_st              in,
  input  logic                fifo_afull,
  output avln_st              out,
  output logic                start,
  output logic                valid,
  output logic [CTR_SIZE-1:0] frame_index,
  output logic [STAT_W-1:0]   discard_cnt,
  output logic [STAT_W-1:0]   runt_cnt,
  output logic [STAT_W-1:0]   err_cnt
);

  localparam int unsigned LEN_W = $clog2(MAX_BEATS + 1);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_BEATS);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BEATS);

  ingr_state_e      state, state_nxt;
  logic [LEN_W-1:0] frame_len, len_nxt, len_inc;
  avln_st           out_nxt;
  logic             start_nxt, valid_nxt, idx_inc;
  logic             discard_inc, runt_inc, err_inc;

  assign len_inc = frame_len + LEN_W'(1);

  always_comb begin
    state_nxt   = state;
    len_nxt     = frame_len;
    out_nxt     = '0;
    start_nxt   = 1'b0;
    valid_nxt   = 1'b0;
    idx_inc     = 1'b0;
    discard_inc = 1'b0;
    runt_inc    = 1'b0;
    err_inc     = 1'b0;
    if (in.valid) begin
      unique case (state)
        IDLE, DISCARD: begin
          if (in.sop) begin
            if (fifo_afull) begin
              discard_inc = 1'b1;
              state_nxt   = in.eop ? IDLE : DISCARD;
            end else begin
              out_nxt   = in;
              start_nxt = 1'b1;
              idx_inc   = 1'b1;
              len_nxt   = LEN_W'(1);
              if (in.eop) begin
                state_nxt = IDLE;
                if (MIN_BEATS <= 1) valid_nxt = 1'b1;
                else                runt_inc  = 1'b1;
              end else begin
                state_nxt = PASS;
              end
            end
          end else if (state == DISCARD) begin
            if (in.eop) state_nxt = IDLE;
          end else begin
            err_inc = 1'b1;
          end
        end
        PASS: begin
          if (in.sop) begin
            // Close the open frame with a synthetic eop; the new frame is dropped.
            out_nxt.valid = 1'b1;
            out_nxt.eop   = 1'b1;
            err_inc       = 1'b1;
            state_nxt     = DISCARD;
          end else begin
            out_nxt = in;
            len_nxt = len_inc;
            if (in.eop) begin
              state_nxt = IDLE;
              if (len_inc >= MIN_LEN) valid_nxt = 1'b1;
              else                    runt_inc  = 1'b1;
            end else if (len_inc == MAX_LEN) begin
              out_nxt.eop   = 1'b1;
              out_nxt.empty = '0;
              err_inc       = 1'b1;
              state_nxt     = DISCARD;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      frame_len   <= '0;
      out         <= '0;
      start       <= 1'b0;
      valid       <= 1'b0;
      frame_index <= '0;
    end else begin
      state       <= state_nxt;
      frame_len   <= len_nxt;
      out         <= out_nxt;
      start       <= start_nxt;
      valid       <= valid_nxt;
      frame_index <= frame_index + CTR_SIZE'(idx_inc);
    end
  end

  sat_counter #(.W(STAT_W)) u_discard_cnt (
    .sys_clk (sys_clk),
    .reset   (reset),
    .inc     (discard_inc),
    .clear   (1'b0),
    .count   (discard_cnt)
  );

  sat_counter #(.W(STAT_W)) u_runt_cnt (
    .sys_clk (sys_clk),
    .reset   (reset),
    .inc     (runt_inc),
    .clear   (1'b0),
    .count   (runt_cnt)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .sys_clk (sys_clk),
    .reset   (reset),
    .inc     (err_inc),
    .clear   (1'b0),
    .count   (err_cnt)
  );

endmodule

// File: tb/tb_ingress_framer.sv
// Bench for ingress_framer: frame-level reference model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_ingress_framer;
  import ingress_framer_pkg::*;

  localparam int unsigned CTR  = 4;
  localparam int unsigned MINB = 4;
  localparam int unsigned MAXB = 256;
  localparam int unsigned SW   = 4;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic           sys_clk = 1'b0;
  logic           reset = 1'b0;
  avln_st         din = '0;
  logic           fifo_afull = 1'b0;
  avln_st         dout;
  logic           start, valid;
  logic [CTR-1:0] frame_index;
  logic [SW-1:0]  discard_cnt, runt_cnt, err_cnt;

  ingress_framer #(
    .CTR_SIZE  (CTR),
    .MIN_BEATS (MINB),
    .MAX_BEATS (MAXB),
    .STAT_W    (SW)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .in          (din),
    .fifo_afull  (fifo_afull),
    .out         (dout),
    .start       (start),
    .valid       (valid),
    .frame_index (frame_index),
    .discard_cnt (discard_cnt),
    .runt_cnt    (runt_cnt),
    .err_cnt     (err_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the beats of the frame currently being forwarded, plus
  // whether we are skipping the rest of a dropped/broken frame.
  avln_st cur_frame[$];
  bit     skipping;
  avln_st exp_out;
  bit     exp_start, exp_valid;
  int     exp_idx, exp_disc, exp_runt, exp_err;

  bit armed = 1'b0;
  int start_seen, valid_seen, beats_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x < STAT_MAX) ? x + 1 : x;
  endfunction

  task automatic model_reset();
    cur_frame.delete();
    skipping  = 1'b0;
    exp_out   = '0;
    exp_start = 1'b0;
    exp_valid = 1'b0;
    exp_idx   = 0;
    exp_disc  = 0;
    exp_runt  = 0;
    exp_err   = 0;
  endtask

  task automatic model_step(input avln_st b, input bit af);
    exp_out   = '0;
    exp_start = 1'b0;
    exp_valid = 1'b0;
    if (!b.valid) return;
    if (b.sop && cur_frame.size() == 0) begin
      if (af) begin
        exp_disc = sat(exp_disc);
        skipping = !b.eop;
      end else begin
        exp_out   = b;
        exp_start = 1'b1;
        exp_idx   = (exp_idx + 1) % (1 << CTR);
        skipping  = 1'b0;
        if (b.eop) begin
          if (MINB <= 1) exp_valid = 1'b1;
          else           exp_runt  = sat(exp_runt);
        end else begin
          cur_frame.push_back(b);
        end
      end
    end else if (b.sop) begin
      exp_out.valid = 1'b1;
      exp_out.eop   = 1'b1;
      exp_err       = sat(exp_err);
      cur_frame.delete();
      skipping = 1'b1;
    end else if (cur_frame.size() > 0) begin
      exp_out = b;
      cur_frame.push_back(b);
      if (b.eop) begin
        if (cur_frame.size() >= MINB) exp_valid = 1'b1;
        else                          exp_runt  = sat(exp_runt);
        cur_frame.delete();
      end else if (cur_frame.size() == MAXB) begin
        exp_out.eop   = 1'b1;
        exp_out.empty = '0;
        exp_err       = sat(exp_err);
        cur_frame.delete();
        skipping = 1'b1;
      end
    end else if (skipping) begin
      if (b.eop) skipping = 1'b0;
    end else begin
      exp_err = sat(exp_err);
    end
  endtask

  always @(negedge sys_clk) begin
    if (armed) begin
      chk("out.valid", dout.valid, exp_out.valid);
      if (exp_out.valid) begin
        chk("out.sop", dout.sop, exp_out.sop);
        chk("out.eop", dout.eop, exp_out.eop);
        chk("out.data", dout.data, exp_out.data);
        chk("out.empty", dout.empty, exp_out.empty);
      end
      chk("start", start, exp_start);
      chk("valid", valid, exp_valid);
      chk("frame_index", frame_index, exp_idx);
      chk("discard_cnt", discard_cnt, exp_disc);
      chk("runt_cnt", runt_cnt, exp_runt);
      chk("err_cnt", err_cnt, exp_err);
      if (start) start_seen++;
      if (valid) valid_seen++;
      if (dout.valid) beats_seen++;
    end
  end

  task automatic beat(input bit v, input bit s, input bit e, input bit af);
    avln_st b;
    b = '0;
    b.valid = v;
    b.sop   = v & s;
    b.eop   = v & e;
    if (v) b.data = $urandom;
    if (v && e) b.empty = EMPTY_W'($urandom_range(0, 3));
    din        = b;
    fifo_afull = af;
    @(posedge sys_clk);
    #1;
    model_step(b, af);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input int len, input bit has_eop, input bit af_sop, input bit af_mid);
    for (int i = 0; i < len; i++)
      beat(1'b1, i == 0, has_eop && (i == len - 1), (i == 0) ? af_sop : af_mid);
  endtask

  task automatic do_reset();
    din        = '0;
    fifo_afull = 1'b0;
    reset      = 1'b1;
    model_reset();
    #1;
    chk("reset out.valid", dout.valid, 0);
    chk("reset start", start, 0);
    chk("reset frame_index", frame_index, 0);
    chk("reset err_cnt", err_cnt, 0);
    chk("reset discard_cnt", discard_cnt, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    reset      = 1'b0;
    start_seen = 0;
    valid_seen = 0;
    beats_seen = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    reset = 1'b1;
    model_reset();
    armed = 1'b1;

    // Three clean frames back to back.
    do_reset();
    send_frame(5, 1, 0, 0);
    send_frame(8, 1, 0, 0);
    send_frame(5, 1, 0, 0);
    idle(2);
    chk("s1 starts", start_seen, 3);
    chk("s1 valids", valid_seen, 3);
    chk("s1 beats", beats_seen, 18);
    chk("s1 frame_index", frame_index, 3);
    chk("s1 err_cnt", err_cnt, 0);

    // Second frame discarded at sop.
    do_reset();
    send_frame(5, 1, 0, 0);
    send_frame(5, 1, 1, 0);
    send_frame(5, 1, 0, 0);
    idle(2);
    chk("s2 discard_cnt", discard_cnt, 1);
    chk("s2 frame_index", frame_index, 2);
    chk("s2 beats", beats_seen, 10);
    chk("s2 starts", start_seen, 2);

    // Oversize frame truncated at MAXB, afull held high mid-frame.
    do_reset();
    send_frame(300, 1, 0, 1);
    send_frame(5, 1, 0, 0);
    idle(2);
    chk("s3 beats", beats_seen, 261);
    chk("s3 err_cnt", err_cnt, 1);
    chk("s3 valids", valid_seen, 1);
    chk("s3 frame_index", frame_index, 2);

    // Missing eop: synthetic close, next frame lost.
    do_reset();
    send_frame(6, 0, 0, 0);
    send_frame(4, 1, 0, 0);
    idle(2);
    chk("s4 beats", beats_seen, 7);
    chk("s4 err_cnt", err_cnt, 1);
    chk("s4 starts", start_seen, 1);
    chk("s4 valids", valid_seen, 0);

    // Orphans then runt frames (2-beat and single-beat).
    do_reset();
    beat(1, 0, 0, 0);
    beat(1, 0, 0, 0);
    send_frame(2, 1, 0, 0);
    idle(2);
    chk("s5 err_cnt", err_cnt, 2);
    chk("s5 runt_cnt", runt_cnt, 1);
    chk("s5 valids", valid_seen, 0);
    chk("s5 beats", beats_seen, 2);
    send_frame(1, 1, 0, 0);
    idle(2);
    chk("s5 single runt_cnt", runt_cnt, 2);
    chk("s5 single frame_index", frame_index, 2);

    // Reset mid-frame: tail becomes orphans.
    do_reset();
    for (int i = 1; i <= 3; i++) beat(1, i == 1, 0, 0);
    do_reset();
    for (int i = 4; i <= 10; i++) beat(1, 0, i == 10, 0);
    send_frame(5, 1, 0, 0);
    idle(2);
    chk("s6 err_cnt", err_cnt, 7);
    chk("s6 frame_index", frame_index, 1);
    chk("s6 starts", start_seen, 1);
    chk("s6 valids", valid_seen, 1);

    // Counter saturation and frame_index wrap.
    do_reset();
    for (int i = 0; i < 20; i++) beat(1, 0, 0, 0);
    idle(1);
    chk("s7 err_cnt sat", err_cnt, STAT_MAX);
    for (int i = 0; i < 17; i++) send_frame(4, 1, 0, 0);
    idle(2);
    chk("s7 frame_index wrap", frame_index, 1);
    chk("s7 valids", valid_seen, 17);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 99);
      if (k < 8) begin
        for (int j = 0, m = $urandom_range(1, 3); j < m; j++)
          beat(1, 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end else if (k < 14) begin
        send_frame($urandom_range(1, 10), 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end else if (k < 16) begin
        send_frame($urandom_range(250, 262), 1, 0, 1'($urandom_range(0, 1)));
      end else begin
        send_frame($urandom_range(1, 12), 1, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
      end
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
